// File: rtl/ram_rsp_pkg.sv
// Shared definitions for the RAM responder: FSM encodings and size defaults.
// Optional parity storage is enabled by defining RAM_RSP_PARITY_EN.
package ram_rsp_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 512;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ram_rsp_array.sv
// Storage array: synchronous write, registered read with a hold register.
// Word width is chosen by the top (data plus parity when RAM_RSP_PARITY_EN).
module ram_rsp_array
  import ram_rsp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WIDTH  = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic             w_ok;
  logic             r_ok;

  // Addresses past DEPTH exist only when the array is not a full power of two.
  if (DEPTH < (1 << ADDR_W)) begin : g_chk
    localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
    assign w_ok = {1'b0, waddr} < LIM;
    assign r_ok = {1'b0, raddr} < LIM;
  end else begin : g_full
    assign w_ok = 1'b1;
    assign r_ok = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we && w_ok) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = r_ok ? mem[raddr[IW-1:0]] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// RAM request responder: post-reset clear, valid/ready requests, buffered reads.
// Define RAM_RSP_PARITY_EN to store even parity and report rsp_perr.
module ram_responder
  import ram_rsp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              e,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done
`ifdef RAM_RSP_PARITY_EN
  ,
  input  logic              inj_perr,
  output logic              rsp_perr
`endif
);

`ifdef RAM_RSP_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int MEM_W = DATA_W + PAR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              rsp_valid_q;
  logic              rsp_valid_d;

  logic              running;
  logic              acc;
  logic              wr_acc;
  logic              rd_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  mem_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign running   = (state_q == ST_RUN);
  assign req_ready = running & e & (~rsp_valid_q | rsp_ready);
  assign acc       = req_valid & req_ready;
  assign wr_acc    = acc & req_wr;
  assign rd_acc    = acc & ~req_wr;

  // A new read on the draining edge keeps rsp_valid high with no bubble.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    if (rd_acc) begin
      rsp_valid_d = 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef RAM_RSP_PARITY_EN
  assign wr_word = {(^req_wdata) ^ inj_perr, req_wdata};
`else
  assign wr_word = req_wdata;
`endif

  assign mem_we    = ~running | wr_acc;
  assign mem_waddr = running ? req_addr : cnt_q;
  assign mem_wdata = running ? wr_word : '0;

  ram_rsp_array #(
    .ADDR_W (ADDR_W),
    .WIDTH  (MEM_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (rd_acc),
    .raddr (req_addr),
    .rdata (mem_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = mem_rdata[DATA_W-1:0];
  assign init_done = running;

`ifdef RAM_RSP_PARITY_EN
  // Clean words XOR to zero over data plus stored parity.
  assign rsp_perr = ^mem_rdata;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: model memory, expected-response queue.
// Parity checks are built when RAM_RSP_PARITY_EN is defined.
module tb_ram_responder;

  logic        clk;
  logic        rst_n;
  logic        e;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [8:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        init_done;
`ifdef RAM_RSP_PARITY_EN
  logic        inj_perr;
  logic        rsp_perr;
  logic        model_p [512];
`endif

  logic [15:0] model [512];
  logic [16:0] exp_q [$];
  int          n_cmp;
  int          n_bad;
  int          stalls;

  ram_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .e         (e),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done)
`ifdef RAM_RSP_PARITY_EN
    ,
    .inj_perr  (inj_perr),
    .rsp_perr  (rsp_perr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responses pop before this edge's acceptance pushes: they are older.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < 512; i++) begin
        model[i] <= '0;
`ifdef RAM_RSP_PARITY_EN
        model_p[i] <= 1'b0;
`endif
      end
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          chk("rsp_data", 32'(rsp_rdata), 32'(exp_q[0][15:0]));
`ifdef RAM_RSP_PARITY_EN
          chk("rsp_perr", 32'(rsp_perr), 32'(exp_q[0][16]));
`endif
          void'(exp_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        if (req_wr) begin
          model[req_addr] <= req_wdata;
`ifdef RAM_RSP_PARITY_EN
          model_p[req_addr] <= inj_perr;
`endif
        end else begin
`ifdef RAM_RSP_PARITY_EN
          exp_q.push_back({model_p[req_addr], model[req_addr]});
`else
          exp_q.push_back({1'b0, model[req_addr]});
`endif
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic wr, input logic [8:0] a,
                        input logic [15:0] d);
    int w;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!req_ready) chk("req_timeout", 32'd0, 32'd1);
    stalls += w;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_init();
    int n;
    int rdy;
    n   = 0;
    rdy = 0;
    while (n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (init_done) break;
      if (req_ready) rdy++;
    end
    chk("init_cycles", 32'(n), 32'd512);
    chk("init_ready_low", 32'(rdy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b1;
    e         = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
`ifdef RAM_RSP_PARITY_EN
    inj_perr  = 1'b0;
`endif
    n_cmp  = 0;
    n_bad  = 0;
    stalls = 0;
    #2;

    do_reset();
    wait_init();
    do_req(1'b0, 9'h1FF, '0);

    for (int i = 0; i < 64; i++) do_req(1'b1, 9'(i), 16'(i));
    stalls = 0;
    for (int i = 0; i < 64; i++) do_req(1'b0, 9'(i), '0);
    chk("burst_stalls", 32'(stalls), 32'd0);
    idle(2);

    rsp_ready = 1'b0;
    do_req(1'b0, 9'd5, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_rdata), 32'h0005);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    idle(1);
    chk("drain_valid", 32'(rsp_valid), 32'd0);

    do_req(1'b1, 9'h100, 16'hBEEF);
    do_req(1'b0, 9'h100, '0);
    idle(2);
    rsp_ready = 1'b0;
    do_req(1'b0, 9'd10, '0);
    e         = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("e0_ready", 32'(req_ready), 32'd0);
    idle(1);
    chk("e0_drained", 32'(rsp_valid), 32'd0);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 9'd3;
    idle(3);
    chk("e0_no_accept", 32'(rsp_valid), 32'd0);
    req_valid = 1'b0;
    e         = 1'b1;

`ifdef RAM_RSP_PARITY_EN
    inj_perr = 1'b1;
    do_req(1'b1, 9'd7, 16'h00FF);
    inj_perr = 1'b0;
    do_req(1'b0, 9'd7, '0);
    do_req(1'b1, 9'd8, 16'h00FF);
    do_req(1'b0, 9'd8, '0);
    idle(2);
`endif

    do_reset();
    idle(200);
    do_reset();
    wait_init();

    rsp_ready = 1'b0;
    do_req(1'b0, 9'h100, '0);
    idle(2);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    do_reset();
    rsp_ready = 1'b1;
    wait_init();
    do_req(1'b0, 9'h100, '0);
    do_req(1'b0, 9'd20, '0);
    idle(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
